// File: rtl/hatch_timer.sv
`default_nettype none
// ============================================================================
// Module   : hatch_timer
// Purpose  : Requests a random value, turns it into a hatch delay, counts it
//            down in prescaled ticks and emits a one-cycle hatch pulse.
//            Define HATCH_TIMER_CNT_EN to add the hatch_cnt event counter.
// Revision : 1.0 - initial release
// ============================================================================
module hatch_timer #(
    parameter int RAND_W    = 7,
    parameter int CNT_W     = 8,
    parameter int MIN_DELAY = 8,
    parameter int TICK_DIV  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [RAND_W-1:0] rand_data,
    input  logic              rand_vld,
    output logic              rand_req,
    output logic              hatch,
    output logic              busy,
    output logic [CNT_W-1:0]  remain
`ifdef HATCH_TIMER_CNT_EN
    ,
    output logic [7:0]        hatch_cnt
`endif
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_HATCH = 2'd3;

    logic [1:0]      r_state;
    logic            r_req;
    logic            r_hatch;
    logic            r_busy;
    logic [CNT_W-1:0] r_remain;
    logic [PS_W-1:0] r_presc;

    logic [1:0]       w_state_nxt;
    logic             w_req_nxt;
    logic             w_hatch_nxt;
    logic [CNT_W-1:0] w_remain_nxt;
    logic [PS_W-1:0]  w_presc_nxt;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_load;
    logic             w_tick;

    // One extra bit catches overflow so the delay saturates instead of wrapping
    assign w_sum  = (CNT_W+1)'(MIN_DELAY) + {{(CNT_W+1-RAND_W){1'b0}}, rand_data};
    assign w_load = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    assign w_tick = (r_presc == PS_W'(TICK_DIV - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_hatch_nxt  = 1'b0;
        w_remain_nxt = r_remain;
        w_presc_nxt  = r_presc;
        if (!en) begin
            w_state_nxt  = S_IDLE;
            w_req_nxt    = 1'b0;
            w_remain_nxt = '0;
            w_presc_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_REQ;
                    w_req_nxt   = 1'b1;
                end
                S_REQ: begin
                    if (rand_vld) begin
                        w_req_nxt    = 1'b0;
                        w_presc_nxt  = '0;
                        w_remain_nxt = w_load;
                        if (w_load == '0) begin
                            w_state_nxt = S_HATCH;
                            w_hatch_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (w_tick) begin
                        w_presc_nxt = '0;
                        if (r_remain == CNT_W'(1)) begin
                            w_remain_nxt = '0;
                            w_hatch_nxt  = 1'b1;
                            w_state_nxt  = S_HATCH;
                        end else begin
                            w_remain_nxt = r_remain - CNT_W'(1);
                        end
                    end else begin
                        w_presc_nxt = r_presc + PS_W'(1);
                    end
                end
                S_HATCH: begin
                    w_state_nxt = S_REQ;
                    w_req_nxt   = 1'b1;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_req_nxt    = 1'b0;
                    w_remain_nxt = '0;
                    w_presc_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_hatch  <= 1'b0;
            r_busy   <= 1'b0;
            r_remain <= '0;
            r_presc  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_hatch  <= w_hatch_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_remain <= w_remain_nxt;
            r_presc  <= w_presc_nxt;
        end
    end

    assign rand_req = r_req;
    assign hatch    = r_hatch;
    assign busy     = r_busy;
    assign remain   = r_remain;

`ifdef HATCH_TIMER_CNT_EN
    logic [7:0] r_hatch_cnt;

    // Survives en=0 so the game can keep a running score across pauses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hatch_cnt <= 8'd0;
        end else if (w_hatch_nxt) begin
            r_hatch_cnt <= r_hatch_cnt + 8'd1;
        end
    end

    assign hatch_cnt = r_hatch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hatch_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hatch_timer
// Purpose  : Directed self-checking bench for hatch_timer (default parameters
//            plus a CNT_W=7 instance for the saturation boundary).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hatch_timer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [6:0] rand_data;
    logic       rand_vld;

    logic       rand_req, hatch, busy;
    logic [7:0] remain;
    logic       rand_req7, hatch7, busy7;
    logic [6:0] remain7;
`ifdef HATCH_TIMER_CNT_EN
    logic [7:0] hatch_cnt;
    logic [7:0] hatch_cnt7;
`endif

    int n_pass  = 0;
    int n_total = 0;

    hatch_timer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rand_data (rand_data),
        .rand_vld  (rand_vld),
        .rand_req  (rand_req),
        .hatch     (hatch),
        .busy      (busy),
        .remain    (remain)
`ifdef HATCH_TIMER_CNT_EN
        ,
        .hatch_cnt (hatch_cnt)
`endif
    );

    hatch_timer #(.CNT_W(7)) u_dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rand_data (rand_data),
        .rand_vld  (rand_vld),
        .rand_req  (rand_req7),
        .hatch     (hatch7),
        .busy      (busy7),
        .remain    (remain7)
`ifdef HATCH_TIMER_CNT_EN
        ,
        .hatch_cnt (hatch_cnt7)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic give_rand(input logic [6:0] data);
        rand_vld  = 1'b1;
        rand_data = data;
        step();
        rand_vld  = 1'b0;
    endtask

    task automatic count_to_hatch(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!hatch && n < 2000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  bad_req, bad_busy;
        rst_n     = 1'b0;
        en        = 1'b1;
        rand_vld  = 1'b1;
        rand_data = 7'd5;

        // T1: reset holds everything low despite en/rand_vld
        repeat (3) step();
        check("rst_rand_req", rand_req, 0);
        check("rst_hatch",    hatch,    0);
        check("rst_busy",     busy,     0);
        check("rst_remain",   remain,   0);
        rand_vld = 1'b0;

        // T2: single egg, data=5 -> delay 13 -> 52 edges
        do_reset();
        en = 1'b1;
        step();
        check("t2_req_up",   rand_req, 1);
        check("t2_busy_req", busy,     1);
        repeat (3) step();
        check("t2_req_held", rand_req, 1);
        give_rand(7'd5);
        check("t2_load",     remain,   13);
        check("t2_req_drop", rand_req, 0);
        repeat (4) step();
        check("t2_first_tick", remain, 12);
        count_to_hatch(n);
        check("t2_hatch_edges", n + 4, 52);
        check("t2_hatch_remain", remain, 0);
        step();
        check("t2_hatch_1cyc", hatch,    0);
        check("t2_req_again",  rand_req, 1);

        // T3: boundary data=127 -> 135 (and 127 saturated with CNT_W=7)
        do_reset();
        en = 1'b1;
        step();
        give_rand(7'd127);
        check("t3_load",     remain,  135);
        check("t3_sat_load", remain7, 127);
        count_to_hatch(n);
        check("t3_hatch_edges", n, 540);

        // T4: abort at remain=4, no hatch afterwards
        do_reset();
        en = 1'b1;
        step();
        give_rand(7'd0);
        check("t4_load", remain, 8);
        n = 0;
        while (remain != 8'd4 && n < 100) begin
            step();
            n++;
        end
        check("t4_reach4", remain, 4);
        en = 1'b0;
        step();
        check("t4_abort_busy",   busy,     0);
        check("t4_abort_remain", remain,   0);
        check("t4_abort_req",    rand_req, 0);
        seen = 1'b0;
        repeat (100) begin
            step();
            if (hatch) seen = 1'b1;
        end
        check("t4_no_hatch", seen, 0);
        en = 1'b1;
        step();
        check("t4_req", rand_req, 1);
        en        = 1'b0;
        rand_vld  = 1'b1;
        rand_data = 7'd5;
        step();
        rand_vld = 1'b0;
        check("t4_prio_remain", remain, 0);
        check("t4_prio_busy",   busy,   0);

        // T5: stray valid during COUNT, then stalled request
        en = 1'b1;
        step();
        give_rand(7'd2);
        check("t5_load", remain, 10);
        rand_vld  = 1'b1;
        rand_data = 7'd100;
        step();
        step();
        rand_vld = 1'b0;
        check("t5_stray", remain, 10);
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        bad_req  = 1'b0;
        bad_busy = 1'b0;
        repeat (200) begin
            step();
            if (!rand_req) bad_req  = 1'b1;
            if (!busy)     bad_busy = 1'b1;
        end
        check("t5_stall_req",  bad_req,  0);
        check("t5_stall_busy", bad_busy, 0);

        // Asynchronous reset mid-countdown clears immediately
        give_rand(7'd3);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_remain", remain, 0);
        check("async_rst_busy",   busy,   0);
        step();
        check("async_rst_hatch",  hatch,  0);
        rst_n = 1'b1;

`ifdef HATCH_TIMER_CNT_EN
        // T6: three eggs counted, survives en toggle, cleared by reset
        do_reset();
        en = 1'b1;
        repeat (3) begin
            n = 0;
            while (!rand_req && n < 10) begin
                step();
                n++;
            end
            give_rand(7'd0);
            count_to_hatch(n);
            check("t6_egg_edges", n, 32);
        end
        check("t6_cnt3", hatch_cnt, 3);
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        check("t6_cnt_keep", hatch_cnt, 3);
        rst_n = 1'b0;
        #1;
        check("t6_cnt_rst", hatch_cnt, 0);
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
